// File: rtl/konami_seq_detector_if.sv
// Button press / configuration / status bundle for konami_seq_detector.
interface konami_seq_detector_if #(
    parameter int unsigned NUM_BUTTONS = 7,
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned MAX_FAILS   = 3
);
    localparam int unsigned BTN_W  = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;
    localparam int unsigned IDX_W  = $clog2(MAX_LEN + 1);
    localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);

    logic [NUM_BUTTONS-1:0] press_i;
    logic                   cfg_we_i;
    logic [IDX_W-1:0]       cfg_addr_i;
    logic [BTN_W-1:0]       cfg_data_i;
    logic                   cfg_len_we_i;
    logic [IDX_W-1:0]       cfg_len_i;
    logic [IDX_W-1:0]       progress_o;
    logic                   unlocked_o;
    logic                   match_o;
    logic                   locked_out_o;
    logic [FAIL_W-1:0]      fail_count_o;

    modport master (
        output press_i, cfg_we_i, cfg_addr_i, cfg_data_i, cfg_len_we_i, cfg_len_i,
        input  progress_o, unlocked_o, match_o, locked_out_o, fail_count_o
    );

    modport slave (
        input  press_i, cfg_we_i, cfg_addr_i, cfg_data_i, cfg_len_we_i, cfg_len_i,
        output progress_o, unlocked_o, match_o, locked_out_o, fail_count_o
    );
endinterface

// File: rtl/konami_seq_detector.sv
// Programmable button-sequence recognizer with inter-press timeout,
// consecutive-failure counting and timed lockout.
module konami_seq_detector #(
    parameter int unsigned NUM_BUTTONS    = 7,
    parameter int unsigned MAX_LEN        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1024
) (
    input logic                 clk_i,
    input logic                 reset_i,
    konami_seq_detector_if.slave bus
);
    localparam int unsigned BTN_W  = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;
    localparam int unsigned IDX_W  = $clog2(MAX_LEN + 1);
    localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int unsigned AW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TO_MAX = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam int unsigned TO_W   = (TO_MAX > 0) ? $clog2(TO_MAX + 1) : 1;
    localparam int unsigned LK_MAX = (LOCKOUT_CYCLES > 0) ? LOCKOUT_CYCLES - 1 : 0;
    localparam int unsigned LK_W   = (LK_MAX > 0) ? $clog2(LK_MAX + 1) : 1;

    typedef enum logic [1:0] {
        ST_MATCH    = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } state_t;

    logic [BTN_W-1:0]  seq_q [MAX_LEN];
    logic [IDX_W-1:0]  len_q;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  progress_q, progress_d;
    logic [FAIL_W-1:0] fail_q, fail_d;
    logic [TO_W-1:0]   idle_q, idle_d;
    logic [LK_W-1:0]   lock_q, lock_d;
    logic              unlocked_q, match_q, match_d, locked_q;

    logic              event_c, onehot_c, hit_c, restart_c;
    logic [BTN_W-1:0]  btn_c;
    logic              seq_ok_c, len_ok_c, cfg_hit_c;
    logic [IDX_W-1:0]  base_c;
    logic [FAIL_W-1:0] fail_inc_c;

    // Press decode and config-write qualification.
    always_comb begin
        btn_c    = '0;
        event_c  = |bus.press_i;
        onehot_c = event_c &&
                   ((bus.press_i & (bus.press_i - NUM_BUTTONS'(1))) == '0);
        for (int unsigned k = 0; k < NUM_BUTTONS; k++) begin
            if (bus.press_i[k]) btn_c = BTN_W'(k);
        end
        seq_ok_c  = bus.cfg_we_i &&
                    (bus.cfg_addr_i < IDX_W'(MAX_LEN)) &&
                    ({1'b0, bus.cfg_data_i} < (BTN_W + 1)'(NUM_BUTTONS));
        len_ok_c  = bus.cfg_len_we_i && (bus.cfg_len_i != '0) &&
                    (bus.cfg_len_i <= IDX_W'(MAX_LEN));
        cfg_hit_c = seq_ok_c || len_ok_c;
    end

    // Sequence table and length register; writes land in any state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) seq_q[i] <= '0;
            len_q <= IDX_W'(MAX_LEN);
        end else begin
            if (seq_ok_c) seq_q[AW'(bus.cfg_addr_i)] <= bus.cfg_data_i;
            if (len_ok_c) len_q <= bus.cfg_len_i;
        end
    end

    // Next-state logic: matching, failure counting, timeout and lockout.
    always_comb begin
        state_d    = state_q;
        progress_d = progress_q;
        fail_d     = fail_q;
        idle_d     = idle_q;
        lock_d     = lock_q;
        match_d    = 1'b0;
        base_c     = (state_q == ST_UNLOCKED) ? '0 : progress_q;
        hit_c      = onehot_c && (btn_c == seq_q[AW'(base_c)]);
        restart_c  = onehot_c && (btn_c == seq_q[0]);
        fail_inc_c = fail_q + FAIL_W'(1);

        case (state_q)
            ST_LOCKOUT: begin
                progress_d = '0;
                idle_d     = '0;
                if (lock_q == '0) begin
                    state_d = ST_MATCH;
                    fail_d  = '0;
                end else begin
                    lock_d = lock_q - LK_W'(1);
                end
            end
            ST_MATCH, ST_UNLOCKED: begin
                if (cfg_hit_c) begin
                    // Config write wins over a same-cycle press.
                    state_d    = ST_MATCH;
                    progress_d = '0;
                    idle_d     = '0;
                end else if (event_c) begin
                    state_d = ST_MATCH;
                    idle_d  = '0;
                    if (hit_c) begin
                        if (base_c + IDX_W'(1) == len_q) begin
                            state_d    = ST_UNLOCKED;
                            progress_d = '0;
                            fail_d     = '0;
                            match_d    = 1'b1;
                        end else begin
                            progress_d = base_c + IDX_W'(1);
                        end
                    end else if (base_c != '0) begin
                        fail_d     = fail_inc_c;
                        progress_d = restart_c ? IDX_W'(1) : '0;
                        if (fail_inc_c == FAIL_W'(MAX_FAILS)) begin
                            state_d    = ST_LOCKOUT;
                            progress_d = '0;
                            lock_d     = LK_W'(LK_MAX);
                        end
                    end else begin
                        progress_d = '0;
                    end
                end else if ((TIMEOUT_CYCLES != 0) && (state_q == ST_MATCH) &&
                             (progress_q != '0)) begin
                    if (idle_q == TO_W'(TO_MAX)) begin
                        progress_d = '0;
                        idle_d     = '0;
                    end else begin
                        idle_d = idle_q + TO_W'(1);
                    end
                end else begin
                    idle_d = '0;
                end
            end
            default: begin
                state_d    = ST_MATCH;
                progress_d = '0;
            end
        endcase
    end

    // State and registered status outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_MATCH;
            progress_q <= '0;
            fail_q     <= '0;
            idle_q     <= '0;
            lock_q     <= '0;
            unlocked_q <= 1'b0;
            match_q    <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            progress_q <= progress_d;
            fail_q     <= fail_d;
            idle_q     <= idle_d;
            lock_q     <= lock_d;
            unlocked_q <= (state_d == ST_UNLOCKED);
            match_q    <= match_d;
            locked_q   <= (state_d == ST_LOCKOUT);
        end
    end

    assign bus.progress_o   = progress_q;
    assign bus.unlocked_o   = unlocked_q;
    assign bus.match_o      = match_q;
    assign bus.locked_out_o = locked_q;
    assign bus.fail_count_o = fail_q;

endmodule

// File: tb/tb_konami_seq_detector.sv
// Self-checking bench for konami_seq_detector: vector records drive the
// inputs, expectations queue up and are checked one cycle later.
module tb_konami_seq_detector;
    localparam int unsigned NB = 7;
    localparam int unsigned ML = 16;
    localparam int unsigned TO = 8;
    localparam int unsigned MF = 3;
    localparam int unsigned LK = 64;

    logic clk;
    logic rst;

    konami_seq_detector_if #(.NUM_BUTTONS(NB), .MAX_LEN(ML), .MAX_FAILS(MF)) bus ();

    konami_seq_detector #(
        .NUM_BUTTONS(NB), .MAX_LEN(ML), .TIMEOUT_CYCLES(TO),
        .MAX_FAILS(MF), .LOCKOUT_CYCLES(LK)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    typedef struct {
        logic       rst;
        logic [6:0] press;
        logic       we;
        logic [4:0] addr;
        logic [2:0] data;
        logic       len_we;
        logic [4:0] len;
        logic [4:0] prog;
        logic       unl;
        logic       mat;
        logic       lck;
        logic [1:0] fail;
        string      name;
    } vec_t;

    typedef struct {
        logic [4:0] prog;
        logic       unl;
        logic       mat;
        logic       lck;
        logic [1:0] fail;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   code[11] = '{0, 0, 1, 1, 2, 3, 2, 3, 4, 5, 6};
    vec_t kon[11];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t pv(input int press, input int prog, input int unl,
                                input int mat, input int lck, input int fail,
                                input string name);
        vec_t v;
        v.rst = 1'b0; v.press = 7'(press);
        v.we = 1'b0; v.addr = '0; v.data = '0; v.len_we = 1'b0; v.len = '0;
        v.prog = 5'(prog); v.unl = 1'(unl); v.mat = 1'(mat);
        v.lck = 1'(lck); v.fail = 2'(fail); v.name = name;
        return v;
    endfunction

    function automatic vec_t cv(input int we, input int addr, input int data,
                                input int len_we, input int len, input int press,
                                input int prog, input int fail, input string name);
        vec_t v;
        v = pv(press, prog, 0, 0, 0, fail, name);
        v.we = 1'(we); v.addr = 5'(addr); v.data = 3'(data);
        v.len_we = 1'(len_we); v.len = 5'(len);
        return v;
    endfunction

    function automatic vec_t rv(input string name);
        vec_t v;
        v = pv(0, 0, 0, 0, 0, 0, name);
        v.rst = 1'b1;
        return v;
    endfunction

    // Drive one cycle of stimulus and queue its expected outputs.
    task automatic drive(input vec_t v);
        exp_t e;
        @(negedge clk);
        rst              = v.rst;
        bus.press_i      = v.press;
        bus.cfg_we_i     = v.we;
        bus.cfg_addr_i   = v.addr;
        bus.cfg_data_i   = v.data;
        bus.cfg_len_we_i = v.len_we;
        bus.cfg_len_i    = v.len;
        e.prog = v.prog; e.unl = v.unl; e.mat = v.mat;
        e.lck = v.lck; e.fail = v.fail; e.name = v.name;
        sb.push_back(e);
    endtask

    // Press the programmed Konami code back to back.
    task automatic run_konami(input int f);
        vec_t v;
        for (int i = 0; i < 11; i++) begin
            v = kon[i];
            v.fail = (i == 10) ? 2'd0 : 2'(f);
            drive(v);
        end
    endtask

    // Compare DUT outputs just after the edge that sampled each vector.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_cmp++;
                if ({bus.progress_o, bus.unlocked_o, bus.match_o, bus.locked_out_o,
                     bus.fail_count_o} !== {e.prog, e.unl, e.mat, e.lck, e.fail}) begin
                    n_bad++;
                    $display("FAIL %s: got prog=%0d unl=%0b mat=%0b lck=%0b fails=%0d, want prog=%0d unl=%0b mat=%0b lck=%0b fails=%0d",
                             e.name, bus.progress_o, bus.unlocked_o, bus.match_o,
                             bus.locked_out_o, bus.fail_count_o,
                             e.prog, e.unl, e.mat, e.lck, e.fail);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.press_i = '0; bus.cfg_we_i = 1'b0; bus.cfg_addr_i = '0;
        bus.cfg_data_i = '0; bus.cfg_len_we_i = 1'b0; bus.cfg_len_i = '0;
        for (int i = 0; i < 11; i++)
            kon[i] = pv(1 << code[i], (i == 10) ? 0 : i + 1, (i == 10) ? 1 : 0,
                        (i == 10) ? 1 : 0, 0, 0, "konami");

        drive(rv("reset"));
        drive(rv("reset_hold"));

        // Program the code; len written together with the last entry.
        for (int i = 0; i < 10; i++) drive(cv(1, i, code[i], 0, 0, 0, 0, 0, "prog_seq"));
        drive(cv(1, 10, 6, 1, 11, 0, 0, 0, "prog_seq_len"));

        run_konami(0);
        drive(pv(0, 0, 1, 0, 0, 0, "unlock_hold"));
        drive(pv(2, 0, 0, 0, 0, 0, "unlock_exit"));

        // Restart on repeated UP.
        drive(pv(1, 1, 0, 0, 0, 0, "rep_up1"));
        drive(pv(1, 2, 0, 0, 0, 0, "rep_up2"));
        drive(pv(1, 1, 0, 0, 0, 1, "rep_restart"));
        drive(pv(2, 0, 0, 0, 0, 2, "rep_down"));

        run_konami(2);
        drive(pv(2, 0, 0, 0, 0, 0, "exit2"));

        // Multi-hot press at progress 4.
        drive(pv(1, 1, 0, 0, 0, 0, "mh_p1"));
        drive(pv(1, 2, 0, 0, 0, 0, "mh_p2"));
        drive(pv(2, 3, 0, 0, 0, 0, "mh_p3"));
        drive(pv(2, 4, 0, 0, 0, 0, "mh_p4"));
        drive(pv(3, 0, 0, 0, 0, 1, "multihot"));

        // Timeout expiry, then an event just before expiry.
        drive(pv(1, 1, 0, 0, 0, 1, "to_up1"));
        drive(pv(1, 2, 0, 0, 0, 1, "to_up2"));
        repeat (7) drive(pv(0, 2, 0, 0, 0, 1, "to_wait"));
        drive(pv(0, 0, 0, 0, 0, 1, "to_expire"));
        drive(pv(1, 1, 0, 0, 0, 1, "to_up1b"));
        drive(pv(1, 2, 0, 0, 0, 1, "to_up2b"));
        repeat (6) drive(pv(0, 2, 0, 0, 0, 1, "to_wait_b"));
        drive(pv(2, 3, 0, 0, 0, 1, "to_event"));

        // Ignored writes keep progress; accepted write beats a matching press.
        drive(cv(0, 0, 0, 1, 0, 0, 3, 1, "len0_ignored"));
        drive(cv(0, 0, 0, 1, 17, 0, 3, 1, "len17_ignored"));
        drive(cv(1, 16, 0, 0, 0, 0, 3, 1, "addr16_ignored"));
        drive(cv(1, 0, 7, 0, 0, 0, 3, 1, "data7_ignored"));
        drive(cv(1, 0, 5, 0, 0, 2, 0, 1, "collide"));
        drive(pv(32, 1, 0, 0, 0, 1, "new_seq0"));
        drive(cv(1, 0, 0, 0, 0, 0, 0, 1, "restore_seq0"));

        // Lockout after three failures.
        run_konami(1);
        drive(pv(2, 0, 0, 0, 0, 0, "exit3"));
        for (int k = 0; k < 3; k++) begin
            drive(pv(1, 1, 0, 0, 0, k, "lk_up"));
            drive(pv(32, 0, 0, 0, (k == 2) ? 1 : 0, k + 1, "lk_fail"));
        end
        for (int j = 1; j < int'(LK); j++)
            drive(pv(j % 2, 0, 0, 0, 1, 3, "lk_window"));
        drive(pv(1, 0, 0, 0, 0, 0, "lk_exit_edge"));
        run_konami(0);
        drive(pv(2, 0, 0, 0, 0, 0, "exit4"));

        // Reset at progress 5 clears table and length.
        for (int i = 0; i < 5; i++) drive(pv(1 << code[i], i + 1, 0, 0, 0, 0, "pre_reset"));
        drive(rv("reset_mid"));
        drive(pv(2, 0, 0, 0, 0, 0, "clr_down"));
        for (int i = 0; i < 15; i++) drive(pv(1, i + 1, 0, 0, 0, 0, "clr_up"));
        drive(pv(1, 0, 1, 1, 0, 0, "clr_unlock16"));
        drive(pv(0, 0, 1, 0, 0, 0, "clr_hold"));

        // Reset during lockout.
        drive(pv(1, 1, 0, 0, 0, 0, "l2_up1"));
        drive(pv(2, 0, 0, 0, 0, 1, "l2_fail1"));
        drive(pv(1, 1, 0, 0, 0, 1, "l2_up2"));
        drive(pv(2, 0, 0, 0, 0, 2, "l2_fail2"));
        drive(pv(1, 1, 0, 0, 0, 2, "l2_up3"));
        drive(pv(2, 0, 0, 0, 1, 3, "l2_lock"));
        repeat (5) drive(pv(0, 0, 0, 0, 1, 3, "l2_window"));
        drive(rv("reset_lock"));
        drive(pv(0, 0, 0, 0, 0, 0, "post_reset_idle"));
        drive(pv(1, 1, 0, 0, 0, 0, "post_reset_up"));
        drive(pv(0, 1, 0, 0, 0, 0, "post_reset_idle2"));

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
